// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard bus between pipeline (master) and stall/flush controller (slave)
interface pipe_hazard_if #(
  parameter int CNT_W = 16
);
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic id_rs1_used;
  logic id_rs2_used;
  logic [3:0] ex_reg_dst;
  logic ex_is_load;
  logic branch_taken;
  logic mem_req;
  logic mem_ready;
  logic halt_in;
  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_stall;
  logic mem_wb_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic halted;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_is_load,
           branch_taken, mem_req, mem_ready, halt_in,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           halted, mem_timeout, stall_cycles
  );
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_is_load,
           branch_taken, mem_req, mem_ready, halt_in,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           halted, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage stall/flush controller (load-use, branch squash, mem wait, halt); ports clk, rst, hazard bus slave
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1) > 8 ? $clog2(MEM_TIMEOUT + 1) : 8;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [CNT_W-1:0] stall_cycles;
  logic mem_timeout, timeout_set, load_use, freeze;
  logic [8:0] ctl;
  assign load_use = bus.ex_is_load && bus.ex_reg_dst != 4'd0 &&
                    ((bus.id_rs1_used && bus.id_rs1 == bus.ex_reg_dst) ||
                     (bus.id_rs2_used && bus.id_rs2 == bus.ex_reg_dst));
  assign freeze = !bus.mem_ready && (state == MEM_WAIT || (state == RUN && bus.mem_req));
  always_comb begin
    ctl = 9'b0;
    state_nx = state;
    wait_nx = wait_cnt;
    timeout_set = 1'b0;
    if (rst) ctl = 9'b00000_1111;
    else if (state == HALTED) ctl = 9'b11111_0000;
    else if (freeze) begin
      ctl = 9'b11110_0001;
      state_nx = MEM_WAIT;
      wait_nx = wait_cnt + 1'b1;
      if (state == MEM_WAIT && wait_cnt == WW'(MEM_TIMEOUT)) begin
        timeout_set = 1'b1;
        state_nx = HALTED;
      end
    end else begin
      wait_nx = '0;
      state_nx = bus.halt_in ? HALTED : RUN;
      ctl = bus.halt_in ? 9'b11110_0000 :
            bus.branch_taken ? 9'b00000_1100 :
            load_use ? 9'b11000_0100 : 9'b0;
    end
  end
  assign {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall, bus.mem_wb_stall,
          bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush} = ctl;
  assign bus.halted = state == HALTED;
  assign bus.mem_timeout = mem_timeout;
  assign bus.stall_cycles = stall_cycles;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      stall_cycles <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      if (timeout_set) mem_timeout <= 1'b1;
      if (ctl[8] && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule
